sfx_event_queue: RTL and testbench

SFX_EVENT_QUEUE -- requirements
Module: sfx_event_queue

---
 rtl/sfx_event_queue.sv | 217 +++++++++++++++++++++
 tb/tb_sfx_event_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_event_queue.sv
// rtl/sfx_event_queue.sv - prioritised sound-event FIFO with paced dispatch to a tone player
//
// Collects one-cycle sound-event requests, keeps the highest-priority one per
// cycle in a small FIFO, and hands entries to a downstream tone player one at
// a time. Each sound is followed by a silent gap before the next one starts.
//
// Optional feature: define SFX_COALESCE_EN to merge a request whose id equals
// the current tail entry instead of queueing a duplicate.
//
// Parameters:
//   DEPTH        FIFO entries (power of 2, 2..16)
//   GAP_CYCLES   silent cycles between sounds
//   BUSY_TIMEOUT cycles to wait for player_busy to rise after a start
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   ev_req[3:0]  in   one-cycle event pulses, bit 3 highest priority
//   player_busy  in   high while the player is sounding
//   play_start   out  one-cycle start pulse to the player
//   play_id[1:0] out  id of the sound being started, held until next start
//   q_count      out  number of queued entries
//   q_full       out  queue holds DEPTH entries
//   drop_cnt     out  saturating count of cycles that discarded a request

module sfx_event_queue #(
  parameter int DEPTH        = 4,
  parameter int GAP_CYCLES   = 100_000,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 ev_req,
  input  logic                       player_busy,
  output logic                       play_start,
  output logic [1:0]                 play_id,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = ($clog2(GAP_CYCLES) > 0) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = ($clog2(BUSY_TIMEOUT) > 0) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic [7:0]      drop_q, drop_d;
  logic            play_start_q, play_start_d;
  logic [1:0]      play_id_q, play_id_d;

  logic            has_req;
  logic            multi_req;
  logic [1:0]      win_id;
  logic            pop;
  logic            bypass;
  logic            merge;
  logic            push;
  logic            full_drop;
`ifdef SFX_COALESCE_EN
  logic [1:0]      tail_id;
`endif

  always_comb begin
    has_req   = |ev_req;
    // More than one bit set means priority losers are discarded this cycle.
    multi_req = (ev_req & (ev_req - 4'd1)) != 4'd0;
    if (ev_req[3])      win_id = 2'd3;
    else if (ev_req[2]) win_id = 2'd2;
    else if (ev_req[1]) win_id = 2'd1;
    else                win_id = 2'd0;

    state_d      = state_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    play_start_d = 1'b0;
    play_id_d    = play_id_q;
    pop          = 1'b0;
    bypass       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!player_busy) begin
          if (count_q != '0) begin
            pop          = 1'b1;
            play_start_d = 1'b1;
            play_id_d    = mem_q[rd_ptr_q];
            state_d      = WAIT_BUSY;
            tmo_d        = '0;
          end else if (has_req) begin
            // Empty queue and idle player: start immediately, never stored.
            bypass       = 1'b1;
            play_start_d = 1'b1;
            play_id_d    = win_id;
            state_d      = WAIT_BUSY;
            tmo_d        = '0;
          end
        end
      end
      WAIT_BUSY: begin
        if (player_busy) begin
          state_d = WAIT_DONE;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Player never acknowledged; still enforce the gap before retrying.
          state_d = GAP;
          tmo_d   = '0;
          gap_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!player_busy) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SFX_COALESCE_EN
    tail_id = mem_q[wr_ptr_q - AW'(1)];
    merge   = has_req && !bypass && (count_q != '0) && (tail_id == win_id);
`else
    merge   = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a full queue still accepts.
    push      = has_req && !bypass && !merge && ((count_q != CNT_FULL) || pop);
    full_drop = has_req && !bypass && !merge && (count_q == CNT_FULL) && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = win_id;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_FULL);

    drop_d = drop_q;
    if ((multi_req || full_drop) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      gap_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      drop_q       <= 8'd0;
      play_start_q <= 1'b0;
      play_id_q    <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      drop_q       <= drop_d;
      play_start_q <= play_start_d;
      play_id_q    <= play_id_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign play_start = play_start_q;
  assign play_id    = play_id_q;
  assign q_count    = count_q;
  assign q_full     = full_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_sfx_event_queue.sv
// tb/tb_sfx_event_queue.sv - self-checking bench for sfx_event_queue
module tb_sfx_event_queue;

  logic       clk;
  logic       reset;
  logic [3:0] ev_req;
  logic       player_busy;
  logic       play_start;
  logic [1:0] play_id;
  logic [2:0] q_count;
  logic       q_full;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  sfx_event_queue #(
    .DEPTH(4),
    .GAP_CYCLES(10),
    .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ev_req(ev_req),
    .player_busy(player_busy),
    .play_start(play_start),
    .play_id(play_id),
    .q_count(q_count),
    .q_full(q_full),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] ev;
    logic       busy;
    logic       start;
    logic [1:0] id;
    logic [2:0] cnt;
    logic       full;
    logic [7:0] drop;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ev_req = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (play_start) begin
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_twice actual=1 expected=0");
      end
    end
    prev_start <= play_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int found;
    int got[$];

    reset = 1'b1;
    ev_req = 4'd0;
    player_busy = 1'b0;

    //           rst  ev       busy  start id     cnt   full  drop
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 2'd1, 3'd1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 4'b0101, 1'b1, 1'b0, 2'd1, 3'd2, 1'b0, 8'd1};
    vecs[6]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 2'd1, 3'd3, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 2'd1, 3'd4, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 2'd1, 3'd4, 1'b1, 8'd2};
    vecs[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 4'b1011, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 8'd1};

    tick();
    for (int i = 0; i < 12; i++) begin
      reset       = vecs[i].rst;
      ev_req      = vecs[i].ev;
      player_busy = vecs[i].busy;
      tick();
      chk($sformatf("v%0d_start", i), int'(play_start), int'(vecs[i].start));
      chk($sformatf("v%0d_id", i),    int'(play_id),    int'(vecs[i].id));
      chk($sformatf("v%0d_cnt", i),   int'(q_count),    int'(vecs[i].cnt));
      chk($sformatf("v%0d_full", i),  int'(q_full),     int'(vecs[i].full));
      chk($sformatf("v%0d_drop", i),  int'(drop_cnt),   int'(vecs[i].drop));
    end
    reset = 1'b0;
    ev_req = 4'd0;
    player_busy = 1'b0;

    // Fill past depth while busy, then drain in arrival order on timeouts.
    do_reset();
    player_busy = 1'b1;
    ev_req = 4'b0001; tick();
    ev_req = 4'b0010; tick();
    ev_req = 4'b0100; tick();
    ev_req = 4'b1000; tick();
    ev_req = 4'b0010; tick();
    ev_req = 4'b0100; tick();
    ev_req = 4'b0000;
    chk("fill_full", int'(q_full), 1);
    chk("fill_cnt", int'(q_count), 4);
    chk("fill_drop", int'(drop_cnt), 2);
    player_busy = 1'b0;
    for (int c = 0; c < 200 && got.size() < 4; c++) begin
      tick();
      if (play_start) got.push_back(int'(play_id));
    end
    chk("order_n", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk($sformatf("order_%0d", i), got[i], i);
    chk("drain_cnt", int'(q_count), 0);

    // Busy never rises: 16 timeout cycles, 10 gap cycles, then next start.
    do_reset();
    ev_req = 4'b0001; tick();
    chk("tmo_first_start", int'(play_start), 1);
    ev_req = 4'b0010; tick();
    chk("tmo_queued", int'(q_count), 1);
    ev_req = 4'b0000;
    n = 1;
    found = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      n++;
      if (play_start) begin
        found = n;
        break;
      end
    end
    chk("tmo_interval", found, 27);
    chk("tmo_id", int'(play_id), 1);

    // Reset while in WAIT_DONE with three entries queued.
    do_reset();
    ev_req = 4'b0010; tick();
    chk("rwd_start", int'(play_start), 1);
    player_busy = 1'b1;
    ev_req = 4'b0000; tick();
    ev_req = 4'b0001; tick();
    ev_req = 4'b0100; tick();
    ev_req = 4'b1000; tick();
    ev_req = 4'b0000;
    chk("rwd_cnt_pre", int'(q_count), 3);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("rwd_cnt", int'(q_count), 0);
    chk("rwd_full", int'(q_full), 0);
    chk("rwd_start_rst", int'(play_start), 0);
    player_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rwd_quiet_%0d", c), int'(play_start), 0);
    end
    ev_req = 4'b0100; tick();
    ev_req = 4'b0000;
    chk("rwd_idle_start", int'(play_start), 1);
    chk("rwd_idle_id", int'(play_id), 2);

    // Duplicate id while busy.
    do_reset();
    player_busy = 1'b1;
    ev_req = 4'b0100; tick();
    ev_req = 4'b0100; tick();
    ev_req = 4'b0000;
`ifdef SFX_COALESCE_EN
    chk("dup_cnt", int'(q_count), 1);
`else
    chk("dup_cnt", int'(q_count), 2);
`endif
    chk("dup_drop", int'(drop_cnt), 0);

    // Drop counter saturation.
    do_reset();
    player_busy = 1'b1;
    ev_req = 4'b1111;
    for (int c = 0; c < 300; c++) tick();
    ev_req = 4'b0000;
    chk("sat_drop", int'(drop_cnt), 255);
`ifdef SFX_COALESCE_EN
    chk("sat_cnt", int'(q_count), 1);
`else
    chk("sat_cnt", int'(q_count), 4);
`endif
    player_busy = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
